// File: rtl/multi_posedge_counter.sv
// N-channel rising-edge counter with continuous (en-gated) and windowed modes,
// per-channel overflow flags and a snapshot of window results.
module multi_posedge_counter #(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 16,
  parameter int WIN_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      en,
  input  logic                      start,
  input  logic                      clr,
  input  logic [WIN_WIDTH-1:0]      win_len,
  input  logic [N_CH-1:0]           in,
  output logic [N_CH*CNT_WIDTH-1:0] cnt,
  output logic [N_CH*CNT_WIDTH-1:0] snap,
  output logic [N_CH-1:0]           ovf,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                             state_q, state_d;
  logic [N_CH-1:0]                    in_d_q;
  logic [N_CH-1:0][CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_WIDTH-1:0]     snap_q, snap_d;
  logic [N_CH-1:0]                    ovf_q, ovf_d;
  logic [WIN_WIDTH-1:0]               timer_q, timer_d;
  logic                               done_q, done_d;

  logic [N_CH-1:0] rise;
  logic            active;

  assign rise   = in & ~in_d_q;
  assign active = (state_q == RUN) || (!mode && en);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    timer_d = timer_q;
    done_d  = 1'b0;

    if (clr) begin
      cnt_d   = '0;
      ovf_d   = '0;
      state_d = IDLE;
    end else if (state_q == IDLE && mode && start) begin
      cnt_d   = '0;
      ovf_d   = '0;
      timer_d = (win_len == '0) ? WIN_WIDTH'(1) : win_len;
      state_d = RUN;
    end else begin
      if (active) begin
        for (int i = 0; i < N_CH; i++) begin
          if (rise[i]) begin
            if (&cnt_q[i]) begin
              ovf_d[i] = 1'b1;
              if (SATURATE == 0) cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
          end
        end
      end
      // Snapshot takes the post-increment value so the last window edge is included.
      if (state_q == RUN) begin
        if (timer_q == WIN_WIDTH'(1)) begin
          state_d = IDLE;
          snap_d  = cnt_d;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - WIN_WIDTH'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_d_q  <= '1;  // an input already high at reset release is not an edge
      cnt_q   <= '0;
      snap_q  <= '0;
      ovf_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_d_q  <= in;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign snap = snap_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
